multicycle_addsub: RTL and testbench

//   Parametrised add/subtract unit computing CHUNK bits per clock through one CHUNK-bit ripple slice.

---
 rtl/arith_pkg.sv | 14 +
 rtl/rca_chunk.sv | 29 ++
 rtl/multicycle_addsub.sv | 123 ++++++++++++
 tb/tb_multicycle_addsub.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared types and constants for the multi-cycle add/subtract unit.
// The state enum drives the handshake FSM; the op codes give names to the in_sub encoding.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple-carry slice built from 1-bit full adders.
// Also reports the carry into the top bit, which the caller needs for signed overflow.
module rca_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] carry;

  always_comb begin
    carry    = '0;
    s        = '0;
    carry[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = carry[CHUNK];
  assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/multicycle_addsub.sv
// Add/subtract unit that pushes one CHUNK-bit slice per clock through a single ripple slice.
// Operands are latched on accept, so the request ports are free to change while the op runs.
module multicycle_addsub
  import arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0]    LAST = CW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}});

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_width_check
      $error("multicycle_addsub: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_t state, next_state;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg, next_sum;
  logic             carry_reg, cout_reg, ovf_reg, zero_reg;
  logic [31:0]      offset;
  logic [CHUNK-1:0] a_slice, b_slice, s_slice;
  logic             slice_cout, slice_c_msb;
  logic             accept, last_slice;

  assign accept     = (state == IDLE) && in_valid;
  assign last_slice = (count == LAST);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)   next_state = BUSY;
      BUSY:    if (last_slice) next_state = DONE;
      DONE:    if (out_ready)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Shifts rather than variable part-selects keep the slice window free of index-width issues.
  always_comb begin
    offset   = 32'(count) * 32'(CHUNK);
    a_slice  = CHUNK'(a_reg >> offset);
    b_slice  = CHUNK'(b_reg >> offset);
    next_sum = (sum_reg & ~(MASK << offset)) | (WIDTH'(s_slice) << offset);
  end

  rca_chunk #(.CHUNK(CHUNK)) u_slice (
    .a     (a_slice),
    .b     (b_slice),
    .cin   (carry_reg),
    .s     (s_slice),
    .cout  (slice_cout),
    .c_msb (slice_c_msb)
  );

  // Subtraction is folded in at accept time: B is inverted and the carry forced to one.
  always_ff @(posedge clock) begin
    if (reset) begin
      count     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
    end else if (accept) begin
      count     <= '0;
      a_reg     <= in_a;
      b_reg     <= in_b ^ {WIDTH{in_sub != OP_ADD}};
      carry_reg <= (in_sub == OP_SUB) ? 1'b1 : in_cin;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
    end else if (state == BUSY) begin
      sum_reg   <= next_sum;
      carry_reg <= slice_cout;
      count     <= count + 1'b1;
      if (last_slice) begin
        cout_reg <= slice_cout;
        ovf_reg  <= slice_c_msb ^ slice_cout;
        zero_reg <= (next_sum == '0);
      end
    end
  end

  assign out_sum  = sum_reg;
  assign out_cout = cout_reg;
  assign out_ovf  = ovf_reg;
  assign out_zero = zero_reg;

endmodule

// File: tb/tb_multicycle_addsub.sv
// Bench for multicycle_addsub: directed handshake/reset cases on the CHUNK=8 instance,
// then random ops run in lockstep on CHUNK=1, 8 and 32 instances against an arithmetic model.
module tb_multicycle_addsub;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        in_sub = 1'b0;

  logic        in_ready [3];
  logic        out_valid [3];
  logic [31:0] out_sum [3];
  logic        out_cout [3];
  logic        out_ovf [3];
  logic        out_zero [3];

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  // Index 0: CHUNK=8, index 1: CHUNK=1, index 2: CHUNK=32
  localparam int CHUNKS [3] = '{8, 1, 32};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    multicycle_addsub #(.WIDTH(32), .CHUNK(CHUNKS[g])) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .out_sum   (out_sum[g]),
      .out_cout  (out_cout[g]),
      .out_ovf   (out_ovf[g]),
      .out_zero  (out_zero[g])
    );
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Model works from the arithmetic meaning of the op, not from slices or carries.
  function automatic void ref_calc(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub,
                                   output logic [31:0] s, output logic co,
                                   output logic ov, output logic z);
    longint          sa, sb, r;
    longint unsigned ua, ub, u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    if (!sub) begin
      u  = ua + ub + longint'(cin);
      r  = sa + sb + longint'(cin);
      co = (u >= 64'h1_0000_0000);
    end else begin
      u  = ua - ub;
      r  = sa - sb;
      co = (ua >= ub);
    end
    s  = u[31:0];
    ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    z  = (s == 32'd0);
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Issue one op on the CHUNK=8 instance and wait for its result, checking the latency.
  task automatic run_op8(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub);
    int lat;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom); in_sub = 1'($urandom);
    lat = -1;
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      step();
      if (out_valid[0]) lat = k;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd4);
  endtask

  logic [31:0] es;
  logic        ec, eo, ez;
  logic [31:0] ra, rb;
  logic        rcin, rsub;
  int          lats [3];
  bit          all_seen;

  initial begin
    // Reset state
    reset = 1'b1;
    step();
    step();
    chk("rst_in_ready", 64'(in_ready[0]), 64'd1);
    chk("rst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("rst_sum", 64'(out_sum[0]), 64'd0);
    chk("rst_flags", {61'd0, out_cout[0], out_ovf[0], out_zero[0]}, 64'd0);
    reset = 1'b0;
    step();

    // Add wrapping to zero
    run_op8("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    chk("add_wrap_sum", 64'(out_sum[0]), 64'h0);
    chk("add_wrap_flags", {61'd0, out_cout[0], out_ovf[0], out_zero[0]}, 64'b101);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("handoff_in_ready", 64'(in_ready[0]), 64'd1);
    chk("handoff_out_valid", 64'(out_valid[0]), 64'd0);

    // Signed overflow on subtraction
    run_op8("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1);
    chk("sub_ovf_sum", 64'(out_sum[0]), 64'h7FFF_FFFF);
    chk("sub_ovf_flags", {61'd0, out_cout[0], out_ovf[0], out_zero[0]}, 64'b110);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Borrow: 0 - 1, with cin set to show it is ignored in subtract mode
    run_op8("sub_borrow", 32'h0, 32'h1, 1'b1, 1'b1);
    chk("sub_borrow_sum", 64'(out_sum[0]), 64'hFFFF_FFFF);
    chk("sub_borrow_flags", {61'd0, out_cout[0], out_ovf[0], out_zero[0]}, 64'b000);

    // Hold in DONE with a stray request: nothing may move
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      in_a = $urandom; in_b = $urandom;
      step();
      chk("hold_valid", 64'(out_valid[0]), 64'd1);
      chk("hold_ready", 64'(in_ready[0]), 64'd0);
      chk("hold_sum", 64'(out_sum[0]), 64'hFFFF_FFFF);
      chk("hold_flags", {61'd0, out_cout[0], out_ovf[0], out_zero[0]}, 64'b000);
    end
    in_valid = 1'b0;
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("after_hold_idle", 64'(in_ready[0]), 64'd1);
    step();
    chk("no_ghost_op", 64'(in_ready[0]), 64'd1);

    // Reset during the second BUSY cycle abandons the op
    in_a = 32'h1234_5678; in_b = 32'h1111_1111; in_sub = 1'b0; in_cin = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midbusy_in_ready", 64'(in_ready[0]), 64'd1);
    chk("midbusy_sum", 64'(out_sum[0]), 64'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("midbusy_no_valid", 64'(out_valid[0]), 64'd0);
    end

    // Random lockstep phase on all three slice widths
    apply_reset();
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom; rb = $urandom; rcin = 1'($urandom); rsub = 1'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      ref_calc(ra, rb, rcin, rsub, es, ec, eo, ez);
      for (int d = 0; d < 3; d++) chk("rnd_idle", 64'(in_ready[d]), 64'd1);
      in_a = ra; in_b = rb; in_cin = rcin; in_sub = rsub; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom); in_sub = 1'($urandom);
      lats = '{-1, -1, -1};
      all_seen = 1'b0;
      for (int k = 1; k <= 40 && !all_seen; k++) begin
        step();
        for (int d = 0; d < 3; d++) if (out_valid[d] && lats[d] < 0) lats[d] = k;
        all_seen = (lats[0] >= 0) && (lats[1] >= 0) && (lats[2] >= 0);
      end
      for (int d = 0; d < 3; d++) begin
        chk("rnd_latency", 64'(lats[d]), 64'(32 / CHUNKS[d]));
        chk("rnd_sum", 64'(out_sum[d]), 64'(es));
        chk("rnd_flags", {61'd0, out_cout[d], out_ovf[d], out_zero[d]},
            {61'd0, ec, eo, ez});
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
